// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_scan_pkg;

   localparam int unsigned NUM_COL = 4;
   localparam int unsigned NUM_ROW = 4;

   // Row lines are pulled up, so an idle matrix reads all ones.
   localparam logic [NUM_ROW-1:0] ROW_IDLE = 4'b1111;

   typedef enum logic [1:0] {
      StScan     = 2'd0,
      StDebounce = 2'd1,
      StPressed  = 2'd2,
      StRelease  = 2'd3
   } state_e;

   // Index of the lowest active-low row bit; lowest index wins on ties.
   function automatic logic [1:0] first_low_row(input logic [NUM_ROW-1:0] row_n);
      logic [1:0] idx;
      idx = '0;
      for (int i = NUM_ROW - 1; i >= 0; i--) begin
         if (!row_n[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // Active-low one-hot column strobe for a column index.
   function automatic logic [NUM_COL-1:0] col_strobe(input logic [1:0] idx);
      return ~(NUM_COL'(1) << idx);
   endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// Matrix-side and key-report signals of the keypad scanner.
interface keypad_scan_if;
   import keypad_scan_pkg::*;

   logic [NUM_COL-1:0] o_col;
   logic [NUM_ROW-1:0] i_row;
   logic [3:0]         o_key;
   logic               o_key_valid;
   logic               o_key_held;

   // master: the scanner itself; slave: the key matrix plus key consumer.
   modport master (
      output o_col, o_key, o_key_valid, o_key_held,
      input  i_row
   );

   modport slave (
      input  o_col, o_key, o_key_valid, o_key_held,
      output i_row
   );

endinterface

// File: rtl/keypad_tick_gen.sv
// Free-running prescaler producing a one-cycle enable every SCAN_DIV clocks.
module keypad_tick_gen #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick_o
);

   localparam int unsigned   CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CntMax);

   // Count 0..SCAN_DIV-1 and wrap on the tick cycle.
   always_comb begin
      cnt_d = tick_o ? '0 : cnt_q + CntW'(1);
   end

   // Prescaler state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: strobes one column at a time, debounces press and
// release on scan ticks and reports the accepted key code.
module keypad_scan
   import keypad_scan_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned DEB_TICKS = 20
) (
   input  logic          clk,
   input  logic          rst_n,
   keypad_scan_if.master kp
);

   localparam int unsigned     DebW   = $clog2(DEB_TICKS) + 1;
   localparam logic [DebW-1:0] DebMax = DebW'(DEB_TICKS - 1);

   logic               tick;
   logic [NUM_ROW-1:0] row_meta_q, row_sync_q;
   state_e             state_q;
   logic [1:0]         col_idx_q, row_idx_q;
   logic [1:0]         col_next;
   logic [DebW-1:0]    deb_cnt_q;
   logic [NUM_COL-1:0] col_q;
   logic [3:0]         key_q;
   logic               key_valid_q, key_held_q;
   logic               hit, row_bit, deb_done, deb_sat;

   keypad_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick_o(tick)
   );

   // Two-flop synchroniser on the asynchronous row lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta_q <= ROW_IDLE;
         row_sync_q <= ROW_IDLE;
      end else begin
         row_meta_q <= kp.i_row;
         row_sync_q <= row_meta_q;
      end
   end

   assign hit      = (row_sync_q != ROW_IDLE);
   assign row_bit  = row_sync_q[row_idx_q];
   assign deb_done = (deb_cnt_q == DebMax);
   assign deb_sat  = (deb_cnt_q == '1);
   assign col_next = col_idx_q + 2'd1;

   // Scan/debounce FSM; outputs are registered alongside the state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StScan;
         col_idx_q   <= '0;
         row_idx_q   <= '0;
         deb_cnt_q   <= '0;
         col_q       <= col_strobe(2'd0);
         key_q       <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         key_valid_q <= 1'b0;
         if (tick) begin
            unique case (state_q)
               StScan: begin
                  if (hit) begin
                     // Column stays frozen while the candidate is confirmed.
                     row_idx_q <= first_low_row(row_sync_q);
                     deb_cnt_q <= '0;
                     state_q   <= StDebounce;
                  end else begin
                     col_idx_q <= col_next;
                     col_q     <= col_strobe(col_next);
                  end
               end
               StDebounce: begin
                  if (!row_bit) begin
                     if (deb_done) begin
                        state_q     <= StPressed;
                        key_q       <= {row_idx_q, col_idx_q};
                        key_valid_q <= 1'b1;
                        key_held_q  <= 1'b1;
                     end else if (!deb_sat) begin
                        deb_cnt_q <= deb_cnt_q + DebW'(1);
                     end
                  end else begin
                     state_q   <= StScan;
                     col_idx_q <= col_next;
                     col_q     <= col_strobe(col_next);
                  end
               end
               StPressed: begin
                  if (row_bit) begin
                     state_q   <= StRelease;
                     deb_cnt_q <= '0;
                  end
               end
               StRelease: begin
                  if (row_bit) begin
                     if (deb_done) begin
                        state_q    <= StScan;
                        key_held_q <= 1'b0;
                        col_idx_q  <= col_next;
                        col_q      <= col_strobe(col_next);
                     end else if (!deb_sat) begin
                        deb_cnt_q <= deb_cnt_q + DebW'(1);
                     end
                  end else begin
                     // Release bounce: back to held without a new pulse.
                     state_q <= StPressed;
                  end
               end
               default: state_q <= StScan;
            endcase
         end
      end
   end

   assign kp.o_col       = col_q;
   assign kp.o_key       = key_q;
   assign kp.o_key_valid = key_valid_q;
   assign kp.o_key_held  = key_held_q;

endmodule
